kronos_lsu_bus_initiator: RTL and testbench
===========================================

Name: kronos_lsu_bus_initiator

Overview:
- Data-bus initiator for one kronos core. Converts a single load/store request from execute into a req/ack transaction on the shared data port.
- Handles byte-lane steering, mask generation and load sign/zero extension.
- Rejects misaligned accesses without touching the bus and aborts transactions that are never acknowledged.
- Sits between the core's execute stage and the compliance-top memory arbiter (data_req/data_ack port).

Parameters:
- TIMEOUT_CYCLES, 64: cycles data_req may stay unacknowledged before abort; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): watchdog counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rstz  in  1  reset, asynchronous, active-low.
- req_valid  in  1  execute presents an access.
- req_ready  out  1  initiator accepts the access this cycle.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access failed.
- resp_cause  out  2  0 = none, 1 = misaligned, 2 = timeout, 3 = illegal size.
- busy  out  1  a transaction is in flight.
- data_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- data_wr_data  out  32  lane-replicated store data.
- data_mask  out  4  byte enables.
- data_wr_en  out  1  store.
- data_req  out  1  bus request.
- data_ack  in  1  bus acknowledge; data_rd_data is valid in the same cycle.
- data_rd_data  in  32  read data.

Behaviour:
- Reset values (asynchronous): state = IDLE; all registered fields = 0; watchdog = 0; data_req, data_wr_en, resp_valid, resp_err, busy = 0; data_mask = 0; resp_cause = 0.
- req_ready = (state == IDLE). An access is accepted when req_valid && req_ready. Accepted fields are registered and held stable until completion.
- State IDLE:
  - Accept with size 3 -> ERR, cause 3.
  - Accept with misalignment (half && addr[0], or word && addr[1:0] != 0) -> ERR, cause 1.
  - Otherwise -> BUS.
- State BUS:
  - data_req = !data_ack (combinational). The request drops in the ack cycle so the registered-ack arbiter never double-grants.
  - data_ack = 1 -> resp_valid = 1 in that same cycle, resp_err = 0, next state IDLE.
  - Each cycle without ack increments the watchdog. When the watchdog reaches TIMEOUT_CYCLES with no ack, go to ERR with cause 2 and drop data_req that cycle.
  - Losing arbitration just extends BUS; addr, data and mask stay stable.
- State ERR: resp_valid = 1, resp_err = 1, resp_cause set, no bus activity; next state IDLE. Error latency is one cycle after acceptance.
- busy = (state != IDLE).
- Minimum load/store latency: accept at cycle N, data_req high at N+1, ack and resp_valid at N+2 when uncontested. The next accept can happen at N+3.
- Mask generation:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Store data: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata. data_wr_en = req_wr while in BUS.
- Load data: shifted = data_rd_data >> (8*addr[1:0]).
  - byte: sign- or zero-extend shifted[7:0].
  - half: sign- or zero-extend shifted[15:0].
  - word: shifted.
- Stores return resp_rdata = 0.
- An ack seen in IDLE or ERR is spurious: ignored, with no state change and no response.
- Reset mid-transaction: data_req drops immediately (asynchronous) and no response is issued.
- When TIMEOUT_CYCLES = 0 the watchdog is held at 0 and the initiator waits indefinitely.

Decomposition:
- Package kronos_lsu_pkg:
  - lsu_size_e (BYTE, HALF, WORD, ILLEGAL)
  - lsu_cause_e (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_TIMEOUT, CAUSE_SIZE)
  - lsu_state_e (IDLE, BUS, ERR)
- Sub-module kronos_lsu_align: purely combinational mask generation, store-lane replication and load extraction/extension. The top holds the FSM and the watchdog.

Test Plan:
- Store byte: addr 0x102, wdata 0xA5, size 0 -> data_addr 0x100, mask 4'b0100, data_wr_data 0xA5A5A5A5, data_wr_en 1. resp_valid 2 cycles after accept, resp_err 0.
- Signed load half: addr 0x202, memory word 0x8001_1234 -> resp_rdata 0xFFFF8001. Repeat with req_unsigned = 1 -> 0x00008001. Load byte at addr 0x201 -> 0x00000012.
- Misaligned word load: addr 0x103 -> no data_req ever asserted; resp_valid, resp_err 1, resp_cause 1 one cycle after accept. req_size 3 -> resp_cause 3.
- Arbitration stall: ack withheld 5 cycles -> data_req held, addr/mask stable, exactly one ack consumed, data_req low in the ack cycle. Back-to-back accepts produce no duplicate grant.
- Timeout with TIMEOUT_CYCLES = 4 and ack never asserted -> resp_err 1, cause 2 after 4 unacked cycles; data_req drops; a later access completes normally.
- Reset pulse while in BUS -> data_req 0 immediately, no resp_valid, req_ready 1 after release. A spurious ack in IDLE produces no response.

Source files
------------

// File: rtl/kronos_lsu_pkg.sv
// Shared types for the kronos load/store bus initiator: access sizes,
// error causes and FSM states, plus the alignment rule used at accept time.
package kronos_lsu_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'd0,
        HALF    = 2'd1,
        WORD    = 2'd2,
        ILLEGAL = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_SIZE     = 2'd3
    } lsu_cause_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ERR  = 2'd2
    } lsu_state_e;

    function automatic logic is_misaligned(lsu_size_e size, logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            HALF:    mis = addr_lo[0];
            WORD:    mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/kronos_lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store-lane replication and
// load extraction with sign/zero extension. Purely combinational.
module kronos_lsu_align
    import kronos_lsu_pkg::*;
(
    input  lsu_size_e   size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wr_data_o,
    output logic [31:0] rd_data_o
);

    logic [31:0] shifted;

    always_comb begin
        mask_o    = 4'b0000;
        wr_data_o = wdata_i;
        rd_data_o = 32'h0;
        shifted   = rdata_i >> {addr_lo_i, 3'b000};
        case (size_i)
            BYTE: begin
                mask_o    = 4'b0001 << addr_lo_i;
                wr_data_o = {4{wdata_i[7:0]}};
                rd_data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                mask_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wr_data_o = {2{wdata_i[15:0]}};
                rd_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            end
            WORD: begin
                mask_o    = 4'b1111;
                wr_data_o = wdata_i;
                rd_data_o = shifted;
            end
            default: begin
                mask_o    = 4'b0000;
                wr_data_o = 32'h0;
                rd_data_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/kronos_lsu_bus_initiator.sv
// Data-bus initiator for one kronos core: turns a single execute-stage
// load/store into a req/ack transaction, with alignment checks and a watchdog.
module kronos_lsu_bus_initiator
    import kronos_lsu_pkg::*;
#(
    parameter  int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic        clk,
    input  logic        rstz,
    // Execute side: an access transfers on a cycle where req_valid && req_ready;
    // req_ready is high only in IDLE, and exactly one resp_valid pulse answers it.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_cause,
    output logic        busy,
    // Shared data port
    output logic [31:0] data_addr,
    output logic [31:0] data_wr_data,
    output logic [3:0]  data_mask,
    output logic        data_wr_en,
    output logic        data_req,
    input  logic        data_ack,
    input  logic [31:0] data_rd_data
);

    lsu_state_e       state_q, state_d;
    lsu_cause_e       cause_q, cause_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             wr_q;
    lsu_size_e        size_q;
    logic             uns_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic             accept;
    logic             timeout_hit;
    lsu_size_e        req_size_e;
    logic [3:0]       lane_mask;
    logic [31:0]      ld_data;

    assign req_size_e  = lsu_size_e'(req_size);
    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign accept      = req_valid && req_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog_q == CNT_W'(TIMEOUT_CYCLES));

    kronos_lsu_align u_align (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rdata_i    (data_rd_data),
        .mask_o     (lane_mask),
        .wr_data_o  (data_wr_data),
        .rd_data_o  (ld_data)
    );

    assign data_addr  = {addr_q[31:2], 2'b00};
    assign data_mask  = (state_q == BUS) ? lane_mask : 4'b0000;
    assign data_wr_en = (state_q == BUS) && wr_q;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            wdog_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= BYTE;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wdog_q  <= wdog_d;
            if (accept) begin
                wr_q    <= req_wr;
                size_q  <= req_size_e;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        wdog_d     = wdog_q;
        data_req   = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_cause = CAUSE_NONE;
        resp_rdata = 32'h0;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (accept) begin
                    if (req_size_e == ILLEGAL) begin
                        cause_d = CAUSE_SIZE;
                        state_d = ERR;
                    end else if (is_misaligned(req_size_e, req_addr[1:0])) begin
                        cause_d = CAUSE_MISALIGN;
                        state_d = ERR;
                    end else begin
                        cause_d = CAUSE_NONE;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                // An ack that lands in the watchdog's final cycle answers a request
                // already seen by the arbiter, so it still completes the access.
                if (data_ack) begin
                    resp_valid = 1'b1;
                    resp_rdata = wr_q ? 32'h0 : ld_data;
                    wdog_d     = '0;
                    state_d    = IDLE;
                end else if (timeout_hit) begin
                    cause_d = CAUSE_TIMEOUT;
                    wdog_d  = '0;
                    state_d = ERR;
                end else begin
                    data_req = 1'b1;
                    if (TIMEOUT_CYCLES != 0) begin
                        wdog_d = wdog_q + CNT_W'(1);
                    end
                end
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                resp_cause = cause_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_kronos_lsu_bus_initiator.sv
// Bench for kronos_lsu_bus_initiator: directed scenarios plus randomized
// accesses checked against a lane-by-lane reference model.
module tb_kronos_lsu_bus_initiator;

    logic        clk;
    logic        rstz;
    logic        sel;
    logic        req_valid, req_wr, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        data_ack;
    logic [31:0] data_rd_data;

    // Instance a: default watchdog; instance b: watchdog of 4 cycles.
    logic        a_req_ready, a_resp_valid, a_resp_err, a_busy, a_data_wr_en, a_data_req;
    logic [31:0] a_resp_rdata, a_data_addr, a_data_wr_data;
    logic [1:0]  a_resp_cause;
    logic [3:0]  a_data_mask;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_busy, b_data_wr_en, b_data_req;
    logic [31:0] b_resp_rdata, b_data_addr, b_data_wr_data;
    logic [1:0]  b_resp_cause;
    logic [3:0]  b_data_mask;

    logic        o_req_ready, o_resp_valid, o_resp_err, o_busy, o_data_wr_en, o_data_req;
    logic [31:0] o_resp_rdata, o_data_addr, o_data_wr_data;
    logic [1:0]  o_resp_cause;
    logic [3:0]  o_data_mask;

    int n_pass;
    int n_total;
    logic [31:0] exp_q[$];

    kronos_lsu_bus_initiator dut_a (
        .clk(clk), .rstz(rstz),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err), .resp_cause(a_resp_cause), .busy(a_busy),
        .data_addr(a_data_addr), .data_wr_data(a_data_wr_data), .data_mask(a_data_mask),
        .data_wr_en(a_data_wr_en), .data_req(a_data_req), .data_ack(data_ack & ~sel),
        .data_rd_data(data_rd_data)
    );

    kronos_lsu_bus_initiator #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rstz(rstz),
        .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err), .resp_cause(b_resp_cause), .busy(b_busy),
        .data_addr(b_data_addr), .data_wr_data(b_data_wr_data), .data_mask(b_data_mask),
        .data_wr_en(b_data_wr_en), .data_req(b_data_req), .data_ack(data_ack & sel),
        .data_rd_data(data_rd_data)
    );

    assign o_req_ready    = sel ? b_req_ready    : a_req_ready;
    assign o_resp_valid   = sel ? b_resp_valid   : a_resp_valid;
    assign o_resp_err     = sel ? b_resp_err     : a_resp_err;
    assign o_resp_cause   = sel ? b_resp_cause   : a_resp_cause;
    assign o_resp_rdata   = sel ? b_resp_rdata   : a_resp_rdata;
    assign o_busy         = sel ? b_busy         : a_busy;
    assign o_data_addr    = sel ? b_data_addr    : a_data_addr;
    assign o_data_wr_data = sel ? b_data_wr_data : a_data_wr_data;
    assign o_data_mask    = sel ? b_data_mask    : a_data_mask;
    assign o_data_wr_en   = sel ? b_data_wr_en   : a_data_wr_en;
    assign o_data_req     = sel ? b_data_req     : a_data_req;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_cause(logic [1:0] size, logic [31:0] addr);
        if (size == 2'd3) return 2'd3;
        if (size == 2'd1 && addr[0]) return 2'd1;
        if (size == 2'd2 && addr[1:0] != 2'b00) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_mask(logic [1:0] size, logic [31:0] addr);
        int n = 1 << size;
        int lo = int'(addr[1:0]);
        logic [3:0] m = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= lo && i < lo + n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(logic [1:0] size, logic [31:0] wdata);
        int n = 1 << size;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = wdata[8*(i % n) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] size, logic uns, logic [31:0] addr,
                                           logic [31:0] mem);
        int n = 1 << size;
        int lo = int'(addr[1:0]);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem[8*(lo+i) +: 8];
        if (!uns && n < 4 && v[8*n-1])
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    // ---------------- driver: one access, checked cycle by cycle ----------------
    task automatic do_access(input logic wr, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] mem, input int stall,
                             output logic [31:0] got);
        int cnt;
        logic [1:0] c;
        logic [31:0] exp_rd;
        c = m_cause(size, addr);
        got = 32'hx;
        cnt = 0;
        while (o_req_ready !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        n_total++;
        if (o_req_ready !== 1'b1) $display("FAIL ready_wait: got %b expected 1", o_req_ready);
        else n_pass++;
        req_wr = wr; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        exp_q.push_back((c != 2'd0 || wr) ? 32'h0 : m_load(size, uns, addr, mem));
        #1;
        if (c != 2'd0) begin
            exp_rd = exp_q.pop_front();
            n_total++;
            if (o_data_req !== 1'b0 || o_resp_valid !== 1'b1 || o_resp_err !== 1'b1 ||
                o_resp_cause !== c || o_resp_rdata !== exp_rd || o_busy !== 1'b1)
                $display("FAIL err_resp: got req=%b vld=%b err=%b cause=%0d rd=%h busy=%b expected 0 1 1 %0d %h 1",
                         o_data_req, o_resp_valid, o_resp_err, o_resp_cause, o_resp_rdata, o_busy,
                         c, exp_rd);
            else n_pass++;
            got = o_resp_rdata;
        end else begin
            for (int k = 0; k < stall; k++) begin
                data_ack = 1'b0;
                data_rd_data = $urandom;
                #1;
                n_total++;
                if (o_data_req !== 1'b1 || o_resp_valid !== 1'b0 ||
                    o_data_addr !== {addr[31:2], 2'b00} || o_data_mask !== m_mask(size, addr) ||
                    o_data_wr_en !== wr || (wr && o_data_wr_data !== m_wdata(size, wdata)))
                    $display("FAIL bus_cycle%0d: got req=%b vld=%b addr=%h mask=%b we=%b wd=%h expected 1 0 %h %b %b %h",
                             k, o_data_req, o_resp_valid, o_data_addr, o_data_mask, o_data_wr_en,
                             o_data_wr_data, {addr[31:2], 2'b00}, m_mask(size, addr), wr,
                             m_wdata(size, wdata));
                else n_pass++;
                step();
            end
            data_ack = 1'b1;
            data_rd_data = mem;
            #1;
            exp_rd = exp_q.pop_front();
            n_total++;
            if (o_data_req !== 1'b0 || o_resp_valid !== 1'b1 || o_resp_err !== 1'b0 ||
                o_resp_cause !== 2'd0 || o_resp_rdata !== exp_rd)
                $display("FAIL ack_cycle: got req=%b vld=%b err=%b cause=%0d rd=%h expected 0 1 0 0 %h",
                         o_data_req, o_resp_valid, o_resp_err, o_resp_cause, o_resp_rdata, exp_rd);
            else n_pass++;
            got = o_resp_rdata;
        end
        step();
        data_ack = 1'b0;
        #1;
        n_total++;
        if (o_resp_valid !== 1'b0 || o_busy !== 1'b0 || o_data_req !== 1'b0 || o_req_ready !== 1'b1)
            $display("FAIL after_resp: got vld=%b busy=%b req=%b rdy=%b expected 0 0 0 1",
                     o_resp_valid, o_busy, o_data_req, o_req_ready);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstz = 1'b0;
        step();
        n_total++;
        if (o_req_ready !== 1'b1 || o_busy !== 1'b0 || o_data_req !== 1'b0 || o_resp_valid !== 1'b0 ||
            o_resp_err !== 1'b0 || o_resp_cause !== 2'd0 || o_data_mask !== 4'b0000 ||
            o_data_wr_en !== 1'b0)
            $display("FAIL reset_state: got rdy=%b busy=%b req=%b vld=%b err=%b cause=%0d mask=%b we=%b expected 1 0 0 0 0 0 0000 0",
                     o_req_ready, o_busy, o_data_req, o_resp_valid, o_resp_err, o_resp_cause,
                     o_data_mask, o_data_wr_en);
        else n_pass++;
        rstz = 1'b1;
        step();
    endtask

    task automatic test_store_byte();
        logic [31:0] got;
        do_access(1'b1, 2'd0, 1'b0, 32'h102, 32'h0000_00A5, 32'hDEAD_BEEF, 1, got);
        n_total++;
        if (got !== 32'h0) $display("FAIL store_rdata: got %h expected 00000000", got);
        else n_pass++;
    endtask

    task automatic test_load_half();
        logic [31:0] got;
        do_access(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 32'h8001_1234, 1, got);
        n_total++;
        if (got !== 32'hFFFF_8001) $display("FAIL lh_signed: got %h expected ffff8001", got);
        else n_pass++;
        do_access(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 32'h8001_1234, 1, got);
        n_total++;
        if (got !== 32'h0000_8001) $display("FAIL lhu: got %h expected 00008001", got);
        else n_pass++;
        do_access(1'b0, 2'd0, 1'b0, 32'h201, 32'h0, 32'h8001_1234, 1, got);
        n_total++;
        if (got !== 32'h0000_0012) $display("FAIL lb: got %h expected 00000012", got);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [31:0] got;
        do_access(1'b0, 2'd2, 1'b0, 32'h103, 32'h0, 32'h1111_2222, 1, got);
        do_access(1'b1, 2'd1, 1'b0, 32'h105, 32'h1234, 32'h0, 1, got);
        do_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1, got);
    endtask

    task automatic test_stall();
        logic [31:0] got;
        do_access(1'b1, 2'd1, 1'b0, 32'h3002, 32'hCAFE_1357, 32'h0, 5, got);
        do_access(1'b0, 2'd2, 1'b0, 32'h3004, 32'h0, 32'h89AB_CDEF, 5, got);
        n_total++;
        if (got !== 32'h89AB_CDEF) $display("FAIL lw_stall: got %h expected 89abcdef", got);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        for (int i = 0; i < 4; i++)
            do_access(i[0], 2'(i % 3), 1'b0, 32'h400 + 32'(4 * i), $urandom, $urandom, 1, got);
    endtask

    task automatic test_timeout();
        logic [31:0] got;
        sel = 1'b1;
        #1;
        req_wr = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_total++;
            if (o_data_req !== 1'b1 || o_resp_valid !== 1'b0)
                $display("FAIL to_wait%0d: got req=%b vld=%b expected 1 0", k, o_data_req, o_resp_valid);
            else n_pass++;
            step();
        end
        #1;
        n_total++;
        if (o_data_req !== 1'b0 || o_resp_valid !== 1'b0)
            $display("FAIL to_drop: got req=%b vld=%b expected 0 0", o_data_req, o_resp_valid);
        else n_pass++;
        step();
        #1;
        n_total++;
        if (o_resp_valid !== 1'b1 || o_resp_err !== 1'b1 || o_resp_cause !== 2'd2 ||
            o_resp_rdata !== 32'h0 || o_data_req !== 1'b0)
            $display("FAIL to_resp: got vld=%b err=%b cause=%0d rd=%h req=%b expected 1 1 2 0 0",
                     o_resp_valid, o_resp_err, o_resp_cause, o_resp_rdata, o_data_req);
        else n_pass++;
        step();
        do_access(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, 32'h9A00_0000, 2, got);
        n_total++;
        if (got !== 32'h0000_009A) $display("FAIL to_recover: got %h expected 0000009a", got);
        else n_pass++;
        sel = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        req_wr = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h800; req_wdata = 32'h5;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        #1;
        n_total++;
        if (o_data_req !== 1'b1) $display("FAIL rst_pre: got req=%b expected 1", o_data_req);
        else n_pass++;
        #2;
        rstz = 1'b0;
        #1;
        n_total++;
        if (o_data_req !== 1'b0 || o_busy !== 1'b0 || o_resp_valid !== 1'b0)
            $display("FAIL rst_async: got req=%b busy=%b vld=%b expected 0 0 0",
                     o_data_req, o_busy, o_resp_valid);
        else n_pass++;
        step();
        rstz = 1'b1;
        #1;
        n_total++;
        if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0 || o_data_req !== 1'b0)
            $display("FAIL rst_release: got rdy=%b vld=%b req=%b expected 1 0 0",
                     o_req_ready, o_resp_valid, o_data_req);
        else n_pass++;
        step();
    endtask

    task automatic test_spurious_ack();
        logic [31:0] got;
        data_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (o_resp_valid !== 1'b0 || o_busy !== 1'b0 || o_data_req !== 1'b0)
                $display("FAIL spurious%0d: got vld=%b busy=%b req=%b expected 0 0 0",
                         k, o_resp_valid, o_busy, o_data_req);
            else n_pass++;
            step();
        end
        data_ack = 1'b0;
        do_access(1'b0, 2'd2, 1'b0, 32'h900, 32'h0, 32'h0BAD_F00D, 1, got);
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int i = 0; i < 40; i++)
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, $urandom, $urandom_range(1, 4), got);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        sel = 1'b0; rstz = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; data_ack = 1'b0; data_rd_data = 32'h0;
        #1;
        test_reset();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_spurious_ack();
        test_random();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
